// File: rtl/ascon_serial_frontend_if.sv
// Signal bundle between the ASCON serial front-end, the GPIO-side load/unload
// streams and the parallel ASCON core.
interface ascon_serial_frontend_if #(
  parameter int LANES   = 1,
  parameter int KEY_W   = 128,
  parameter int NONCE_W = 128,
  parameter int AD_W    = 40,
  parameter int DATA_W  = 104,
  parameter int TAG_W   = 128,
  parameter int CNT_W   = 16
);
  logic               in_valid;
  logic [LANES-1:0]   key_si;
  logic [LANES-1:0]   nonce_si;
  logic [LANES-1:0]   ad_si;
  logic [LANES-1:0]   data_si;
  logic               start;
  logic               decrypt;
  logic [KEY_W-1:0]   core_key;
  logic [NONCE_W-1:0] core_nonce;
  logic [AD_W-1:0]    core_ad;
  logic [DATA_W-1:0]  core_din;
  logic               core_decrypt;
  logic               core_start;
  logic               core_ready;
  logic [DATA_W-1:0]  core_dout;
  logic [TAG_W-1:0]   core_tag;
  logic [LANES-1:0]   data_so;
  logic [LANES-1:0]   tag_so;
  logic               so_valid;
  logic               busy;
  logic               load_err;
  logic [CNT_W-1:0]   cycles;

  // Master is the pin/core environment, slave is the front-end itself.
  modport master (
    output in_valid, key_si, nonce_si, ad_si, data_si, start, decrypt,
           core_ready, core_dout, core_tag,
    input  core_key, core_nonce, core_ad, core_din, core_decrypt, core_start,
           data_so, tag_so, so_valid, busy, load_err, cycles
  );

  modport slave (
    input  in_valid, key_si, nonce_si, ad_si, data_si, start, decrypt,
           core_ready, core_dout, core_tag,
    output core_key, core_nonce, core_ad, core_din, core_decrypt, core_start,
           data_so, tag_so, so_valid, busy, load_err, cycles
  );
endinterface

// File: rtl/ascon_serial_frontend.sv
// Serial front-end for the ASCON AEAD core: deserialises key/nonce/AD/data,
// starts the core, times it, and serialises the result and tag back out.
module ascon_serial_frontend #(
  parameter int LANES   = 1,
  parameter int KEY_W   = 128,
  parameter int NONCE_W = 128,
  parameter int AD_W    = 40,
  parameter int DATA_W  = 104,
  parameter int TAG_W   = 128,
  parameter int CNT_W   = 16
) (
  input logic clk,
  input logic rst_n,
  ascon_serial_frontend_if.slave bus
);
  localparam int MAX_KN    = (KEY_W > NONCE_W) ? KEY_W : NONCE_W;
  localparam int MAX_AD    = (AD_W > DATA_W) ? AD_W : DATA_W;
  localparam int MAX_IN    = (MAX_KN > MAX_AD) ? MAX_KN : MAX_AD;
  localparam int MAX_OUT   = (DATA_W > TAG_W) ? DATA_W : TAG_W;
  localparam int IN_BEATS  = MAX_IN / LANES;
  localparam int OUT_BEATS = MAX_OUT / LANES;
  localparam int ICW       = $clog2(IN_BEATS + 1);
  localparam int OCW       = $clog2(OUT_BEATS + 1);

  localparam logic [ICW-1:0] IN_LAST  = ICW'(IN_BEATS - 1);
  localparam logic [ICW-1:0] KEY_B    = ICW'(KEY_W / LANES);
  localparam logic [ICW-1:0] NONCE_B  = ICW'(NONCE_W / LANES);
  localparam logic [ICW-1:0] AD_B     = ICW'(AD_W / LANES);
  localparam logic [ICW-1:0] DATA_B   = ICW'(DATA_W / LANES);
  localparam logic [OCW-1:0] OUT_LAST = OCW'(OUT_BEATS - 1);

  typedef enum logic [2:0] {IDLE, LOADED, START, WAIT, UNLOAD} state_t;

  state_t             state_q;
  logic [ICW-1:0]     inCnt_q;
  logic [OCW-1:0]     outCnt_q;
  logic [KEY_W-1:0]   key_q;
  logic [NONCE_W-1:0] nonce_q;
  logic [AD_W-1:0]    ad_q;
  logic [DATA_W-1:0]  din_q;
  logic [DATA_W-1:0]  resSh_q;
  logic [TAG_W-1:0]   tagSh_q;
  logic               coreDec_q;
  logic               coreStart_q;
  logic               soValid_q;
  logic               loadErr_q;
  logic [CNT_W-1:0]   cycles_q;
  logic [CNT_W-1:0]   cycles_d;
  logic               lastBeat;

  assign cycles_d = (cycles_q == {CNT_W{1'b1}}) ? cycles_q : cycles_q + CNT_W'(1);
  // A beat that completes the load wins over a simultaneous start.
  assign lastBeat = bus.in_valid && (inCnt_q == IN_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      inCnt_q     <= '0;
      outCnt_q    <= '0;
      key_q       <= '0;
      nonce_q     <= '0;
      ad_q        <= '0;
      din_q       <= '0;
      resSh_q     <= '0;
      tagSh_q     <= '0;
      coreDec_q   <= 1'b0;
      coreStart_q <= 1'b0;
      soValid_q   <= 1'b0;
      loadErr_q   <= 1'b0;
      cycles_q    <= '0;
    end else begin
      coreStart_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            if (inCnt_q < KEY_B)   key_q   <= (key_q << LANES)   | KEY_W'(bus.key_si);
            if (inCnt_q < NONCE_B) nonce_q <= (nonce_q << LANES) | NONCE_W'(bus.nonce_si);
            if (inCnt_q < AD_B)    ad_q    <= (ad_q << LANES)    | AD_W'(bus.ad_si);
            if (inCnt_q < DATA_B)  din_q   <= (din_q << LANES)   | DATA_W'(bus.data_si);
            inCnt_q <= inCnt_q + ICW'(1);
            if (lastBeat) state_q <= LOADED;
          end
          if (bus.start && !lastBeat) loadErr_q <= 1'b1;
        end
        LOADED: begin
          if (bus.start) begin
            coreDec_q   <= bus.decrypt;
            cycles_q    <= '0;
            loadErr_q   <= 1'b0;
            coreStart_q <= 1'b1;
            state_q     <= START;
          end
        end
        START: state_q <= WAIT;
        WAIT: begin
          cycles_q <= cycles_d;
          if (bus.core_ready) begin
            resSh_q   <= bus.core_dout;
            tagSh_q   <= bus.core_tag;
            outCnt_q  <= '0;
            soValid_q <= 1'b1;
            state_q   <= UNLOAD;
          end
        end
        UNLOAD: begin
          // Shifting in zeros makes a field drive 0 once it is exhausted.
          resSh_q  <= resSh_q >> LANES;
          tagSh_q  <= tagSh_q >> LANES;
          outCnt_q <= outCnt_q + OCW'(1);
          if (outCnt_q == OUT_LAST) begin
            soValid_q <= 1'b0;
            inCnt_q   <= '0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.core_key     = key_q;
  assign bus.core_nonce   = nonce_q;
  assign bus.core_ad      = ad_q;
  assign bus.core_din     = din_q;
  assign bus.core_decrypt = coreDec_q;
  assign bus.core_start   = coreStart_q;
  assign bus.data_so      = resSh_q[LANES-1:0];
  assign bus.tag_so       = tagSh_q[LANES-1:0];
  assign bus.so_valid     = soValid_q;
  assign bus.busy         = (state_q != IDLE) && (state_q != LOADED);
  assign bus.load_err     = loadErr_q;
  assign bus.cycles       = cycles_q;
endmodule

// File: tb/tb_ascon_serial_frontend.sv
// Bench for ascon_serial_frontend: one LANES=1 and one LANES=8 instance share
// the stimulus; an ASCON-128 behavioural core answers core_start.
module tb_ascon_serial_frontend;
  localparam logic [127:0] K   = 128'h6d4f8bbf60ec05a07b201d4e5b2119ac;
  localparam logic [127:0] N   = 128'h05885e606e1271b8d47a74c7b297a318;
  localparam logic [39:0]  AD  = 40'h4153434f4e;
  localparam logic [103:0] PT  = 104'h6173636f6e2d756e6963617373;
  localparam logic [103:0] CT  = 104'h18490112f8d5867a830748390b;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b0;
  logic inValid = 1'b0;
  logic [7:0] kB = '0, nB = '0, aB = '0, dB = '0;
  logic startR = 1'b0, decR = 1'b0, coreReady = 1'b0;
  logic [103:0] coreDout = '0;
  logic [127:0] coreTag = '0;
  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  ascon_serial_frontend_if #(.LANES(1)) bus1 ();
  ascon_serial_frontend_if #(.LANES(8)) bus8 ();

  ascon_serial_frontend #(.LANES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  ascon_serial_frontend #(.LANES(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  assign bus1.in_valid   = inValid & ~sel;
  assign bus1.key_si     = kB[0];
  assign bus1.nonce_si   = nB[0];
  assign bus1.ad_si      = aB[0];
  assign bus1.data_si    = dB[0];
  assign bus1.start      = startR & ~sel;
  assign bus1.decrypt    = decR;
  assign bus1.core_ready = coreReady & ~sel;
  assign bus1.core_dout  = coreDout;
  assign bus1.core_tag   = coreTag;
  assign bus8.in_valid   = inValid & sel;
  assign bus8.key_si     = kB;
  assign bus8.nonce_si   = nB;
  assign bus8.ad_si      = aB;
  assign bus8.data_si    = dB;
  assign bus8.start      = startR & sel;
  assign bus8.decrypt    = decR;
  assign bus8.core_ready = coreReady & sel;
  assign bus8.core_dout  = coreDout;
  assign bus8.core_tag   = coreTag;

  logic [127:0] mKey, mNonce;
  logic [39:0]  mAd;
  logic [103:0] mDin;
  logic [7:0]   mDataSo, mTagSo;
  logic [15:0]  mCycles;
  logic mDec, mStart, mValid, mBusy, mErr;
  assign mKey    = sel ? bus8.core_key     : bus1.core_key;
  assign mNonce  = sel ? bus8.core_nonce   : bus1.core_nonce;
  assign mAd     = sel ? bus8.core_ad      : bus1.core_ad;
  assign mDin    = sel ? bus8.core_din     : bus1.core_din;
  assign mDataSo = sel ? bus8.data_so      : {7'b0, bus1.data_so};
  assign mTagSo  = sel ? bus8.tag_so       : {7'b0, bus1.tag_so};
  assign mCycles = sel ? bus8.cycles       : bus1.cycles;
  assign mDec    = sel ? bus8.core_decrypt : bus1.core_decrypt;
  assign mStart  = sel ? bus8.core_start   : bus1.core_start;
  assign mValid  = sel ? bus8.so_valid     : bus1.so_valid;
  assign mBusy   = sel ? bus8.busy         : bus1.busy;
  assign mErr    = sel ? bus8.load_err     : bus1.load_err;

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    else passes++;
  endtask

  function automatic logic [63:0] ror(input logic [63:0] v, input int r);
    return (v >> r) | (v << (64 - r));
  endfunction

  function automatic logic [319:0] perm(input logic [319:0] s, input int rounds);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    {x0, x1, x2, x3, x4} = s;
    for (int r = 12 - rounds; r < 12; r++) begin
      x2 ^= 64'(((15 - r) << 4) | r);
      x0 ^= x4; x4 ^= x3; x2 ^= x1;
      t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
      x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
      x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
      x0 ^= ror(x0, 19) ^ ror(x0, 28);
      x1 ^= ror(x1, 61) ^ ror(x1, 39);
      x2 ^= ror(x2, 1) ^ ror(x2, 6);
      x3 ^= ror(x3, 10) ^ ror(x3, 17);
      x4 ^= ror(x4, 7) ^ ror(x4, 41);
    end
    return {x0, x1, x2, x3, x4};
  endfunction

  // ASCON-128 with a 5-byte AD and a 13-byte message (one full, one partial block).
  task automatic asconRef(input logic [127:0] k, input logic [127:0] n, input logic [39:0] a,
                          input logic [103:0] d, input logic dec,
                          output logic [103:0] o, output logic [127:0] t);
    logic [319:0] s;
    s = perm({64'h80400c0600000000, k, n}, 12);
    s[127:0] ^= k;
    s[319:256] ^= {a, 8'h80, 16'h0};
    s = perm(s, 6);
    s[0] ^= 1'b1;
    if (!dec) begin
      s[319:256] ^= d[103:40];
      o[103:40] = s[319:256];
      s = perm(s, 6);
      s[319:256] ^= {d[39:0], 8'h80, 16'h0};
      o[39:0] = s[319:280];
    end else begin
      o[103:40] = s[319:256] ^ d[103:40];
      s[319:256] = d[103:40];
      s = perm(s, 6);
      o[39:0] = s[319:280] ^ d[39:0];
      s[319:280] = d[39:0];
      s[279:272] ^= 8'h80;
    end
    s[255:128] ^= k;
    s = perm(s, 12);
    t = s[127:0] ^ k;
  endtask

  function automatic logic [7:0] beatOf(input logic [127:0] f, input int w, input int b, input int l);
    logic [127:0] mask;
    if (b >= w / l) return 8'($urandom);
    mask = (128'd1 << l) - 128'd1;
    return 8'((f >> (w - (b + 1) * l)) & mask);
  endfunction

  task automatic applyStimulus(input logic [127:0] k, input logic [127:0] n, input logic [39:0] a,
                               input logic [103:0] d, input int fromB, input int toB,
                               input logic startLast);
    int l = sel ? 8 : 1;
    for (int b = fromB; b < toB; b++) begin
      @(negedge clk);
      inValid = 1'b1;
      kB = beatOf(k, 128, b, l);
      nB = beatOf(n, 128, b, l);
      aB = beatOf({88'b0, a}, 40, b, l);
      dB = beatOf({24'b0, d}, 104, b, l);
      startR = startLast && (b == toB - 1);
    end
    @(negedge clk);
    inValid = 1'b0;
    startR = 1'b0;
    kB = 8'($urandom);
  endtask

  task automatic checkZero(input string tag);
    checkOutput({tag, "_key"}, mKey, '0);
    checkOutput({tag, "_ctl"}, {mStart, mValid, mBusy, mDec, mErr, mCycles, mDataSo, mTagSo}, '0);
  endtask

  // Called at a negedge with the front-end LOADED; abortAt=0 resets in WAIT,
  // abortAt>0 resets after that many unload beats, -1 runs to completion.
  task automatic runOp(input logic dec, input int lat, input logic [103:0] expD,
                       input logic [127:0] expT, input int abortAt);
    int l = sel ? 8 : 1;
    int outBeats = 128 / l;
    logic [103:0] cd;
    logic [127:0] ct, accD, accT;
    logic allValid;
    startR = 1'b1;
    decR = dec;
    @(negedge clk);
    startR = 1'b0;
    decR = 1'($urandom);
    checkOutput("core_start", {127'b0, mStart}, 128'd1);
    checkOutput("core_decrypt", {127'b0, mDec}, {127'b0, dec});
    checkOutput("load_err_clr", {127'b0, mErr}, 128'd0);
    asconRef(mKey, mNonce, mAd, mDin, mDec, cd, ct);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      if (i == 0) checkOutput("wait_ctl", {124'b0, mStart, mBusy, mDec, mValid}, {124'b0, 1'b0, 1'b1, dec, 1'b0});
      if (abortAt == 0 && i == lat / 2) begin
        rst_n = 1'b0;
        #1 checkZero("rst_wait");
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
    end
    coreReady = 1'b1;
    coreDout = cd;
    coreTag = ct;
    @(negedge clk);
    coreReady = 1'b0;
    coreDout = 104'($urandom);
    accD = '0;
    accT = '0;
    allValid = 1'b1;
    for (int b = 0; b < outBeats; b++) begin
      if (b > 0) @(negedge clk);
      allValid &= mValid;
      accD |= 128'(mDataSo) << (b * l);
      accT |= 128'(mTagSo) << (b * l);
      if (abortAt > 0 && b == abortAt) begin
        rst_n = 1'b0;
        #1 checkZero("rst_unload");
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
    end
    checkOutput("so_valid_run", {127'b0, allValid}, 128'd1);
    checkOutput("result", accD, {24'b0, expD});
    checkOutput("tag", accT, expT);
    @(negedge clk);
    checkOutput("end_ctl", {126'b0, mValid, mBusy}, 128'd0);
    checkOutput("cycles", {112'b0, mCycles}, 128'(lat));
  endtask

  initial begin
    logic [103:0] refD;
    logic [127:0] tag1, refT, rk, rn, rd;
    logic [39:0] ra;
    logic rdec;
    int rlat;
    repeat (2) @(negedge clk);
    checkZero("reset");
    rst_n = 1'b1;
    asconRef(K, N, AD, PT, 1'b0, refD, tag1);

    $display("[TB] LANES=1 encrypt, 37-cycle core");
    applyStimulus(K, N, AD, PT, 0, 128, 1'b0);
    checkOutput("core_key", mKey, K);
    checkOutput("core_nonce", mNonce, N);
    checkOutput("core_ad", {88'b0, mAd}, {88'b0, AD});
    checkOutput("core_din", {24'b0, mDin}, {24'b0, PT});
    checkOutput("loaded_idle", {126'b0, mBusy, mErr}, 128'd0);
    runOp(1'b0, 37, CT, tag1, -1);

    $display("[TB] LANES=1 decrypt");
    applyStimulus(K, N, AD, CT, 0, 128, 1'b0);
    runOp(1'b1, 10, PT, tag1, -1);

    $display("[TB] LANES=8, start on final beat");
    sel = 1'b1;
    applyStimulus(K, N, AD, PT, 0, 16, 1'b1);
    checkOutput("final_beat_start", {126'b0, mStart, mErr}, 128'd0);
    checkOutput("core_key8", mKey, K);
    runOp(1'b0, 5, CT, tag1, -1);

    $display("[TB] early start after 50 beats");
    sel = 1'b0;
    applyStimulus(K, N, AD, PT, 0, 50, 1'b0);
    startR = 1'b1;
    @(negedge clk);
    startR = 1'b0;
    checkOutput("early_start", {125'b0, mErr, mBusy, mStart}, {125'b0, 3'b100});
    applyStimulus(K, N, AD, PT, 50, 128, 1'b0);
    checkOutput("err_kept", {127'b0, mErr}, 128'd1);
    checkOutput("core_din_resume", {24'b0, mDin}, {24'b0, PT});
    runOp(1'b0, 3, CT, tag1, -1);

    $display("[TB] reset in WAIT and mid-UNLOAD");
    applyStimulus(N, K, AD, CT, 0, 128, 1'b0);
    runOp(1'b0, 12, '0, '0, 0);
    applyStimulus(K, N, AD, PT, 0, 128, 1'b0);
    runOp(1'b0, 8, CT, tag1, 40);
    applyStimulus(K, N, AD, PT, 0, 128, 1'b0);
    runOp(1'b0, 4, CT, tag1, -1);

    $display("[TB] randomized operations");
    for (int it = 0; it < 6; it++) begin
      sel = 1'($urandom);
      rk = {$urandom, $urandom, $urandom, $urandom};
      rn = {$urandom, $urandom, $urandom, $urandom};
      rd = {$urandom, $urandom, $urandom, $urandom};
      ra = {8'($urandom), $urandom};
      rdec = 1'($urandom);
      rlat = $urandom_range(1, 20);
      asconRef(rk, rn, ra, rd[103:0], rdec, refD, refT);
      applyStimulus(rk, rn, ra, rd[103:0], 0, sel ? 16 : 128, 1'b0);
      checkOutput("rand_fields", mKey ^ mNonce ^ {88'b0, mAd} ^ {24'b0, mDin},
                  rk ^ rn ^ {88'b0, ra} ^ {24'b0, rd[103:0]});
      runOp(rdec, rlat, refD, refT, -1);
    end

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
